// File: rtl/store_align_unit_pkg.sv
// rtl/store_align_unit_pkg.sv - shared size codes, strobe type and FSM states for the store aligner
package store_align_unit_pkg;

  // Access size code: bytes = 1 << code. The wide codes only apply to wide buses.
  typedef enum logic [2:0] {
    MSIZE1  = 3'd0,
    MSIZE2  = 3'd1,
    MSIZE4  = 3'd2,
    MSIZE8  = 3'd3,
    MSIZE16 = 3'd4,
    MSIZE32 = 3'd5
  } msize_t;

  // Widest bus the size codes can describe (MSIZE32 -> 256-bit bus).
  localparam int unsigned MAX_BYTES = 32;

  // Strobe container for the widest bus; each block narrows it to its own BYTES.
  typedef logic [MAX_BYTES-1:0] strobe_max_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } store_align_state_t;

endpackage

// File: rtl/store_lane_shift.sv
// rtl/store_lane_shift.sv - lane shifter producing both candidate beats of a store
module store_lane_shift
  import store_align_unit_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  localparam int BYTES      = DATA_WIDTH / 8,
  localparam int OFF_W      = $clog2(BYTES)
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [OFF_W-1:0]      off,
  input  logic [2:0]            size,
  output logic [DATA_WIDTH-1:0] beat0_data,
  output logic [DATA_WIDTH-1:0] beat1_data,
  output logic [BYTES-1:0]      beat0_strobe,
  output logic [BYTES-1:0]      beat1_strobe,
  output logic                  split
);

  typedef logic [BYTES-1:0] strobe_t;

  logic [8:0]         n;
  logic [OFF_W:0]     spill;
  logic [OFF_W+3:0]   shift0;
  logic [OFF_W+3:0]   shift1;
  logic [2*BYTES-1:0] base_mask;
  logic [2*BYTES-1:0] mask;

  // Byte mask over two bus words, shifted into place; data moved up for beat 0 and the overflow brought down for beat 1.
  always_comb begin
    n      = 9'd1 << size;
    spill  = (OFF_W+1)'(BYTES) - {1'b0, off};
    shift0 = {1'b0, off, 3'b000};
    shift1 = {spill, 3'b000};
    for (int i = 0; i < 2*BYTES; i++) begin
      base_mask[i] = (i < int'(n));
    end
    mask         = base_mask << off;
    beat0_data   = data << shift0;
    beat1_data   = data >> shift1;
    beat0_strobe = strobe_t'(mask[BYTES-1:0]);
    beat1_strobe = strobe_t'(mask[2*BYTES-1:BYTES]);
    split        = (10'(off) + 10'(n)) > 10'(BYTES);
  end

endmodule

// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - store-data aligner issuing one or two strobed bus beats per store
// Optional misaligned-store trap: STORE_ALIGN_MISALIGN_TRAP_EN
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter  int DATA_WIDTH = 64,
  parameter  int ADDR_WIDTH = 64,
  localparam int BYTES      = DATA_WIDTH / 8,
  localparam int OFF_W      = $clog2(BYTES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [2:0]            req_size,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic [BYTES-1:0]      bus_strobe,
  output logic                  bus_last,
  output logic                  done_valid,
  output logic                  done_err
);

  store_align_state_t    state_q, next_state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  msize_t                size_q;

  logic                  accept;
  logic                  size_err;
  logic                  misalign;
  logic                  req_err;
  logic                  beat_fire;
  logic [ADDR_WIDTH-1:0] base_addr;

  logic [DATA_WIDTH-1:0] beat0_data, beat1_data;
  logic [BYTES-1:0]      beat0_strobe, beat1_strobe;
  logic                  split;

`ifdef STORE_ALIGN_MISALIGN_TRAP_EN
  logic [OFF_W-1:0]      req_off;
  logic [OFF_W-1:0]      align_mask;
`endif

  store_lane_shift #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_shift (
    .data         (data_q),
    .off          (addr_q[OFF_W-1:0]),
    .size         (size_q),
    .beat0_data   (beat0_data),
    .beat1_data   (beat1_data),
    .beat0_strobe (beat0_strobe),
    .beat1_strobe (beat1_strobe),
    .split        (split)
  );

  // Request-side decode: a store is rejected if it is wider than the bus (or misaligned when trapping).
  always_comb begin
    size_err = int'(req_size) > OFF_W;
`ifdef STORE_ALIGN_MISALIGN_TRAP_EN
    req_off    = req_addr[OFF_W-1:0];
    align_mask = OFF_W'((32'd1 << req_size) - 32'd1);
    misalign   = |(req_off & align_mask);
`else
    misalign   = 1'b0;
`endif
    req_err = size_err || misalign;
  end

  assign accept    = req_valid && req_ready;
  assign beat_fire = bus_valid && bus_ready;
  assign base_addr = {addr_q[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  // Next-state and beat selection; bus outputs are driven straight from held registers so they cannot move during a stall.
  always_comb begin
    next_state = state_q;
    req_ready  = (state_q == ST_IDLE);
    bus_valid  = 1'b0;
    bus_addr   = '0;
    bus_data   = '0;
    bus_strobe = '0;
    bus_last   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !req_err) next_state = ST_BEAT0;
      end
      ST_BEAT0: begin
        bus_valid  = 1'b1;
        bus_addr   = base_addr;
        bus_data   = beat0_data;
        bus_strobe = beat0_strobe;
        bus_last   = !split;
        if (bus_ready) next_state = split ? ST_BEAT1 : ST_IDLE;
      end
      ST_BEAT1: begin
        bus_valid  = 1'b1;
        bus_addr   = base_addr + ADDR_WIDTH'(BYTES);
        bus_data   = beat1_data;
        bus_strobe = beat1_strobe;
        bus_last   = 1'b1;
        if (bus_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register; reset abandons any store in flight.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= next_state;
  end

  // Capture the request fields on accept; they stay put until the store retires.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q <= '0;
      data_q <= '0;
      size_q <= MSIZE1;
    end else if (accept) begin
      addr_q <= req_addr;
      data_q <= req_data;
      size_q <= msize_t'(req_size);
    end
  end

  // One-cycle completion pulse after the last beat, or right after accepting a rejected store.
  always_ff @(posedge clk) begin
    if (!reset) begin
      done_valid <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      done_valid <= (accept && req_err) || (beat_fire && bus_last);
      done_err   <= accept && req_err;
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - randomized self-checking bench for store_align_unit (64-bit bus)
module tb_store_align_unit;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [2:0]    req_size = '0;
  logic          bus_valid;
  logic          bus_ready = 1'b0;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_data;
  logic [NB-1:0] bus_strobe;
  logic          bus_last;
  logic          done_valid;
  logic          done_err;

  int checks = 0;
  int errors = 0;

  // Expected outcome of the current store, built byte by byte from the addresses each byte lands on.
  logic          exp_err;
  int            exp_nbeats;
  logic [AW-1:0] exp_addr [2];
  logic [DW-1:0] exp_data [2];
  logic [NB-1:0] exp_strb [2];

  store_align_unit #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_size   (req_size),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_addr   (bus_addr),
    .bus_data   (bus_data),
    .bus_strobe (bus_strobe),
    .bus_last   (bus_last),
    .done_valid (done_valid),
    .done_err   (done_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic model(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] sz);
    int            n;
    int            beat;
    int            lane;
    logic [AW-1:0] base;
    logic [AW-1:0] ba;
    exp_err    = (sz > 3'd3);
    exp_nbeats = 0;
    base       = a & ~(AW'(NB - 1));
    exp_addr[0] = base;
    exp_addr[1] = base + AW'(NB);
    for (int b = 0; b < 2; b++) begin
      exp_data[b] = '0;
      exp_strb[b] = '0;
    end
    if (!exp_err) begin
      n = 1 << sz;
      for (int k = 0; k < n; k++) begin
        ba   = a + AW'(k);
        beat = ((ba & ~(AW'(NB - 1))) == base) ? 0 : 1;
        lane = int'(ba % NB);
        exp_data[beat][lane*8 +: 8] = d[k*8 +: 8];
        exp_strb[beat][lane]        = 1'b1;
        if (beat + 1 > exp_nbeats) exp_nbeats = beat + 1;
      end
    end
  endtask

  function automatic logic [DW-1:0] trim(input logic [DW-1:0] d, input logic [2:0] sz);
    logic [DW-1:0] m;
    if (sz >= 3'd3) return d;
    m = (64'd1 << (8 << sz)) - 64'd1;
    return d & m;
  endfunction

  // Waits (bounded) for req_ready, presents one request and returns one cycle after the accept edge.
  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] sz);
    int guard = 0;
    while (req_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got %0b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = sz;
    model(a, d, sz);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Consumes the expected beats with stalls in [lo,hi] per beat, then checks the completion cycle.
  task automatic drain(input int lo, input int hi);
    int   stall;
    logic last_exp;
    if (!exp_err) begin
      for (int b = 0; b < exp_nbeats; b++) begin
        stall    = $urandom_range(hi, lo);
        last_exp = (b == exp_nbeats - 1);
        for (int s = 0; s <= stall; s++) begin
          bus_ready = (s == stall);
          checks++;
          if ({bus_valid, bus_addr, bus_data, bus_strobe, bus_last} !==
              {1'b1, exp_addr[b], exp_data[b], exp_strb[b], last_exp}) begin
            errors++;
            $display("FAIL beat%0d got v=%0b a=%h d=%h s=%h l=%0b want a=%h d=%h s=%h l=%0b",
                     b, bus_valid, bus_addr, bus_data, bus_strobe, bus_last,
                     exp_addr[b], exp_data[b], exp_strb[b], last_exp);
          end
          checks++;
          if ({done_valid, req_ready} !== 2'b00) begin
            errors++;
            $display("FAIL busy_flags got done=%0b ready=%0b want 0 0", done_valid, req_ready);
          end
          @(posedge clk); #1;
        end
      end
      bus_ready = 1'b0;
    end
    checks++;
    if ({done_valid, done_err, bus_valid, req_ready} !== {1'b1, exp_err, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL done got done=%0b err=%0b bvalid=%0b ready=%0b want 1 %0b 0 1",
               done_valid, done_err, bus_valid, req_ready, exp_err);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    checks++;
    if ({bus_valid, bus_last, bus_addr, bus_data, bus_strobe, done_valid, done_err, req_ready} !==
        {1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got v=%0b l=%0b a=%h d=%h s=%h dv=%0b de=%0b rdy=%0b want all 0, ready 1",
               bus_valid, bus_last, bus_addr, bus_data, bus_strobe, done_valid, done_err, req_ready);
    end
  endtask

  task automatic test_byte_store();
    issue(64'h1003, 64'hAB, 3'd0);
    checks++;
    if ({bus_addr, bus_strobe, bus_data[31:24], bus_last} !== {64'h1000, 8'h08, 8'hAB, 1'b1}) begin
      errors++;
      $display("FAIL byte_store got a=%h s=%h d=%h l=%0b want 1000 08 ab 1",
               bus_addr, bus_strobe, bus_data[31:24], bus_last);
    end
    drain(0, 0);
    @(posedge clk); #1;
    checks++;
    if (done_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width got %0b want 0", done_valid);
    end
  endtask

  task automatic test_split_word();
    issue(64'h2006, 64'h11223344, 3'd2);
    checks++;
    if ({bus_strobe, bus_data[63:48]} !== {8'hC0, 16'h3344}) begin
      errors++;
      $display("FAIL split_beat0 got s=%h d=%h want c0 3344", bus_strobe, bus_data[63:48]);
    end
    drain(0, 1);
  endtask

  task automatic test_stall();
    issue(64'h3000, 64'h0123_4567_89AB_CDEF, 3'd3);
    drain(5, 5);
  endtask

  task automatic test_size_error();
    for (int sz = 4; sz < 8; sz++) begin
      issue({$urandom, $urandom}, {$urandom, $urandom}, 3'(sz));
      drain(0, 0);
    end
  endtask

  task automatic test_busy_wait();
    logic [AW-1:0] a2;
    logic [DW-1:0] d2;
    issue(64'h4005, 64'hCAFE_F00D, 3'd2);
    a2 = 64'h5001;
    d2 = 64'h7788;
    req_valid = 1'b1;
    req_addr  = a2;
    req_data  = d2;
    req_size  = 3'd1;
    drain(2, 3);
    @(posedge clk); #1;
    req_valid = 1'b0;
    model(a2, d2, 3'd1);
    drain(0, 0);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [2:0]    sz;
    for (int i = 0; i < 200; i++) begin
      sz = ($urandom_range(9, 0) < 8) ? 3'($urandom_range(3, 0)) : 3'($urandom_range(7, 4));
      a  = {$urandom, $urandom};
      if ($urandom_range(9, 0) == 0) a = 64'hFFFF_FFFF_FFFF_FFF8 | AW'($urandom_range(7, 0));
      d  = trim({$urandom, $urandom}, sz);
      issue(a, d, sz);
      drain(0, 2);
    end
  endtask

  task automatic test_reset_midflight();
    issue(64'h2006, 64'h11223344, 3'd2);
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    checks++;
    if ({bus_valid, bus_addr, bus_strobe, bus_last} !== {1'b1, exp_addr[1], exp_strb[1], 1'b1}) begin
      errors++;
      $display("FAIL beat1_stall got v=%0b a=%h s=%h l=%0b want 1 %h %h 1",
               bus_valid, bus_addr, bus_strobe, bus_last, exp_addr[1], exp_strb[1]);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checks++;
    if ({bus_valid, done_valid, req_ready, bus_strobe} !== {1'b0, 1'b0, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL reset_midflight got v=%0b dv=%0b rdy=%0b s=%h want 0 0 1 00",
               bus_valid, done_valid, req_ready, bus_strobe);
    end
    @(posedge clk); #1;
    checks++;
    if (done_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done got %0b want 0", done_valid);
    end
  endtask

  initial begin
    test_reset();
    test_byte_store();
    test_split_word();
    test_stall();
    test_size_error();
    test_busy_wait();
    test_random();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
- Parametrised store-data aligner and sequencer between the memory stage and the data bus.
- Accepts one store per valid/ready handshake: unaligned address, right-justified data, size code.
- Produces one or two bus-width beats, each with lane-shifted data, per-byte strobe and word-aligned address.
- Signals completion (or a size error) with a one-cycle done pulse.

Parameters:
- DATA_WIDTH, 64, bus data width in bits; power of two, minimum 32. BYTES = DATA_WIDTH/8; OFF_W = log2(BYTES).
- ADDR_WIDTH, 64, address width in bits.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-low.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit can accept a request.
- req_addr  in  ADDR_WIDTH  byte address, any alignment.
- req_data  in  DATA_WIDTH  store data, right-justified (low bytes).
- req_size  in  3  msize_t: bytes = 1 << req_size.
- bus_valid  out  1  beat valid.
- bus_ready  in  1  bus accepts beat.
- bus_addr  out  ADDR_WIDTH  beat address; low OFF_W bits are zero.
- bus_data  out  DATA_WIDTH  lane-aligned beat data.
- bus_strobe  out  BYTES  per-byte write enable.
- bus_last  out  1  final beat of the current store.
- done_valid  out  1  one-cycle completion pulse.
- done_err  out  1  qualifies done_valid; request rejected.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State returns to IDLE; any in-flight store is dropped with no done pulse.
  - Registered outputs clear: bus_valid=0, bus_last=0, bus_addr=0, bus_data=0, bus_strobe=0, done_valid=0, done_err=0.
  - req_ready is high in the first cycle after reset.
- FSM states: IDLE, BEAT0, BEAT1.
- req_ready = (state==IDLE). Accept = req_valid && req_ready. Request fields are registered on accept.
- Decode of an accepted request:
  - off = addr[OFF_W-1:0]; n = 1 << size; mask = (2^n - 1) zero-extended to 2*BYTES bits, then shifted left by off.
  - size > OFF_W: error. Stay IDLE. Next cycle done_valid=1, done_err=1. No bus beat is issued.
  - Otherwise go to BEAT0.
- BEAT0:
  - bus_valid=1; bus_addr = addr with low OFF_W bits cleared.
  - bus_data = (data << 8*off) truncated to DATA_WIDTH; bus_strobe = mask[BYTES-1:0].
  - split = (off + n > BYTES); bus_last = !split.
- BEAT1:
  - bus_addr = BEAT0 address + BYTES, wrapping modulo 2^ADDR_WIDTH.
  - bus_data = data >> 8*(BYTES-off); bus_strobe = mask[2*BYTES-1:BYTES]; bus_last=1.
- Hold rule: while bus_valid && !bus_ready, all bus_* outputs stay stable. bus_valid never drops without a handshake, except on reset.
- Transitions on handshake:
  - BEAT0 with !split → IDLE.
  - BEAT0 with split → BEAT1; bus_valid stays high, no bubble.
  - BEAT1 → IDLE.
- Completion: the cycle after the final handshake, done_valid=1 and done_err=0. req_ready is high in that same cycle.
- Latency: accept at cycle N → beat at N+1 → with bus_ready, done at N+2. Split store done at N+3 minimum.
- Throughput: one aligned store per 2 cycles. Requests presented while busy wait; there is no buffering.
- Total strobe popcount over all beats of a store equals n.

Optional Feature:
- Macro: STORE_ALIGN_MISALIGN_TRAP_EN.
- Defined: a request with addr mod n != 0 is treated like the size error — no bus beat, done_valid=1 and done_err=1 one cycle after accept. The BEAT1 state is unreachable and may be optimised out.
- Undefined: misaligned stores are legal and split as described in Behaviour.

Decomposition:
- Shared pipes package holds:
  - msize_t (MSIZE1/2/4/8, extended with MSIZE16/32 for wider buses).
  - strobe type parametrised by BYTES.
  - state enum store_align_state_t.
- Sub-module store_lane_shift (combinational): takes data, off, size; returns the beat-0 and beat-1 data and strobes. Instantiated once; the FSM selects the beat.

Test Plan:
- DATA_WIDTH=64, addr=0x1003, size=0 (byte), data=0xAB → one beat: addr 0x1000, strobe 0x08, bus_data[31:24]=0xAB, bus_last=1; done 2 cycles after accept.
- addr=0x2006, size=2 (word), data=0x11223344 → beat0 addr 0x2000, strobe 0xC0, data[63:48]=0x3344; beat1 addr 0x2008, strobe 0x03, data[15:0]=0x1122.
  - With STORE_ALIGN_MISALIGN_TRAP_EN defined: no beat; done_err=1.
- addr=0x3000, size=3, bus_ready held low 5 cycles → bus_* stable, bus_valid high throughout; done one cycle after bus_ready rises.
- size=4 with DATA_WIDTH=64 → no bus_valid; done_valid=done_err=1 one cycle after accept.
- DATA_WIDTH=128, addr=0x0F, size=1, data=0xBEEF → beat0 strobe bit15 only (0x8000), data[127:120]=0xEF; beat1 addr 0x10, strobe 0x0001, data[7:0]=0xBE.
- reset low during BEAT1 stall → next cycle bus_valid=0, no done pulse, req_ready=1.
